// File: rtl/pend_priority_encoder_if.sv
// Event/issue bus between event sources, the pending priority encoder and its consumer.
// Signals:
//   req_in    event pulses, one bit per channel
//   mask      per-channel eligibility (1 = may be selected)
//   clr_all   synchronous clear of pending bits and output stage
//   out_idx   issued channel index
//   out_valid out_idx holds an issued channel
//   out_ready consumer accepts when out_valid && out_ready
//   pending   current pending register
//   overflow  one-cycle pulse: an event merged into an already pending bit
// Modports: slave = encoder, master = sources/consumer side.
interface pend_priority_encoder_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) ();
    logic [N-1:0]     req_in;
    logic [N-1:0]     mask;
    logic             clr_all;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     pending;
    logic             overflow;

    modport slave (
        input  req_in, mask, clr_all, out_ready,
        output out_idx, out_valid, pending, overflow
    );

    modport master (
        output req_in, mask, clr_all, out_ready,
        input  out_idx, out_valid, pending, overflow
    );
endinterface

// File: rtl/pend_priority_encoder.sv
// Registered pending-event priority encoder.
// Latches event pulses into a sticky pending register and issues one eligible channel index
// per cycle over a valid/ready handshake, by fixed MSB-first priority (RR_MODE=0) or
// round-robin (RR_MODE=1, last-served channel lowest priority).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pend_priority_encoder_if slave modport (see interface header)
// IDX_W must equal $clog2(N).
module pend_priority_encoder #(
    parameter int unsigned N       = 8,
    parameter int unsigned IDX_W   = 3,
    parameter bit          RR_MODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pend_priority_encoder_if.slave  bus
);

    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     cand, pop_vec;
    logic [IDX_W-1:0] idx_q, last_q;
    logic [IDX_W-1:0] sel, fix_sel, rr_sel, rr_start;
    logic [IDX_W:0]   rr_off, rr_sum;
    logic [2*N-1:0]   cand_rot;
    logic             valid_q, overflow_q, overflow_d;
    logic             any_cand, load_en;

    assign cand     = pending_q & bus.mask;
    assign any_cand = |cand;
    assign load_en  = !valid_q || bus.out_ready;

    // Fixed priority: highest set index wins (later loop iterations override earlier ones).
    always_comb begin
        fix_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) fix_sel = IDX_W'(i);
        end
    end

    // Round-robin: rotate cand so the channel after last_q sits at bit 0, take the lowest
    // set bit, then map the offset back to a channel index modulo N.
    always_comb begin
        rr_start = (last_q == IDX_W'(N - 1)) ? '0 : last_q + 1'b1;
        cand_rot = {cand, cand} >> rr_start;
        rr_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_rot[i]) rr_off = (IDX_W + 1)'(i);
        end
        rr_sum = {1'b0, rr_start} + rr_off;
        if (rr_sum >= (IDX_W + 1)'(N)) begin
            rr_sel = IDX_W'(rr_sum - (IDX_W + 1)'(N));
        end else begin
            rr_sel = IDX_W'(rr_sum);
        end
    end

    assign sel = RR_MODE ? rr_sel : fix_sel;

    // Pop the selected channel when it is loaded; clr_all overrides the load entirely.
    always_comb begin
        pop_vec = '0;
        if (load_en && any_cand && !bus.clr_all) begin
            pop_vec = N'(1) << sel;
        end
        // A new event wins over a pop of the same bit, so it is not lost.
        pending_d  = bus.clr_all ? '0 : ((pending_q & ~pop_vec) | bus.req_in);
        overflow_d = !bus.clr_all && |(bus.req_in & pending_q & ~pop_vec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            last_q     <= IDX_W'(N - 1);
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            if (bus.clr_all) begin
                valid_q <= 1'b0;
            end else if (load_en) begin
                valid_q <= any_cand;
                if (any_cand) begin
                    idx_q <= sel;
                    if (RR_MODE) last_q <= sel;
                end
            end
        end
    end

    assign bus.out_idx   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pend_priority_encoder.sv
// Directed bench: one fixed-priority and one round-robin encoder (N=8) side by side.
module tb_pend_priority_encoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pend_priority_encoder_if #(.N(8), .IDX_W(3)) fx ();
    pend_priority_encoder_if #(.N(8), .IDX_W(3)) rr ();

    pend_priority_encoder #(.N(8), .IDX_W(3), .RR_MODE(1'b0)) dut_fix (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fx.slave)
    );

    pend_priority_encoder #(.N(8), .IDX_W(3), .RR_MODE(1'b1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (fx.pending !== 8'h00 || fx.out_valid !== 1'b0 || fx.out_idx !== 3'd0 ||
            fx.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_fix got pend=%h v=%b idx=%0d ovf=%b want 00 0 0 0",
                     fx.pending, fx.out_valid, fx.out_idx, fx.overflow);
        end
        checks++;
        if (rr.pending !== 8'h00 || rr.out_valid !== 1'b0 || rr.out_idx !== 3'd0 ||
            rr.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_rr got pend=%h v=%b idx=%0d ovf=%b want 00 0 0 0",
                     rr.pending, rr.out_valid, rr.out_idx, rr.overflow);
        end
    endtask

    task automatic test_fixed_priority();
        logic [2:0] exp_idx [3];
        logic [7:0] exp_pend [3];
        exp_idx  = '{3'd5, 3'd2, 3'd0};
        exp_pend = '{8'h05, 8'h01, 8'h00};
        fx.out_ready = 1'b1;
        fx.req_in    = 8'b0010_0101;
        tick();
        fx.req_in = 8'h00;
        checks++;
        if (fx.pending !== 8'h25 || fx.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fix_latch got pend=%h v=%b want 25 0", fx.pending, fx.out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (fx.out_valid !== 1'b1 || fx.out_idx !== exp_idx[k] ||
                fx.pending !== exp_pend[k]) begin
                failures++;
                $display("FAIL fix_issue%0d got v=%b idx=%0d pend=%h want 1 %0d %h", k,
                         fx.out_valid, fx.out_idx, fx.pending, exp_idx[k], exp_pend[k]);
            end
        end
        tick();
        checks++;
        if (fx.out_valid !== 1'b0 || fx.pending !== 8'h00) begin
            failures++;
            $display("FAIL fix_drain got v=%b pend=%h want 0 00", fx.out_valid, fx.pending);
        end
    endtask

    task automatic test_backpressure();
        fx.out_ready = 1'b0;
        fx.req_in    = 8'h20;
        tick();
        fx.req_in = 8'h00;
        tick();
        checks++;
        if (fx.out_valid !== 1'b1 || fx.out_idx !== 3'd5 || fx.pending !== 8'h00) begin
            failures++;
            $display("FAIL bp_first got v=%b idx=%0d pend=%h want 1 5 00",
                     fx.out_valid, fx.out_idx, fx.pending);
        end
        fx.req_in = 8'h80;
        tick();
        fx.req_in = 8'h00;
        checks++;
        if (fx.out_valid !== 1'b1 || fx.out_idx !== 3'd5 || fx.pending !== 8'h80) begin
            failures++;
            $display("FAIL bp_hold got v=%b idx=%0d pend=%h want 1 5 80",
                     fx.out_valid, fx.out_idx, fx.pending);
        end
        fx.out_ready = 1'b1;
        tick();
        checks++;
        if (fx.out_valid !== 1'b1 || fx.out_idx !== 3'd7 || fx.pending !== 8'h00) begin
            failures++;
            $display("FAIL bp_release got v=%b idx=%0d pend=%h want 1 7 00",
                     fx.out_valid, fx.out_idx, fx.pending);
        end
        tick();
    endtask

    task automatic test_round_robin();
        rr.out_ready = 1'b1;
        rr.req_in    = 8'hFF;
        tick();
        checks++;
        if (rr.pending !== 8'hFF || rr.out_valid !== 1'b0 || rr.overflow !== 1'b0) begin
            failures++;
            $display("FAIL rr_latch got pend=%h v=%b ovf=%b want ff 0 0",
                     rr.pending, rr.out_valid, rr.overflow);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (rr.out_valid !== 1'b1 || rr.out_idx !== 3'(k % 8) || rr.overflow !== 1'b1) begin
                failures++;
                $display("FAIL rr_seq%0d got v=%b idx=%0d ovf=%b want 1 %0d 1", k,
                         rr.out_valid, rr.out_idx, rr.overflow, k % 8);
            end
        end
        rr.req_in  = 8'h00;
        rr.clr_all = 1'b1;
        tick();
        rr.clr_all = 1'b0;
        checks++;
        if (rr.pending !== 8'h00 || rr.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_clear got pend=%h v=%b want 00 0", rr.pending, rr.out_valid);
        end
    endtask

    task automatic test_masking();
        fx.out_ready = 1'b1;
        fx.mask      = 8'h7F;
        fx.req_in    = 8'h81;
        tick();
        fx.req_in = 8'h00;
        tick();
        checks++;
        if (fx.out_valid !== 1'b1 || fx.out_idx !== 3'd0 || fx.pending !== 8'h80) begin
            failures++;
            $display("FAIL mask_issue got v=%b idx=%0d pend=%h want 1 0 80",
                     fx.out_valid, fx.out_idx, fx.pending);
        end
        tick();
        checks++;
        if (fx.out_valid !== 1'b0 || fx.pending !== 8'h80) begin
            failures++;
            $display("FAIL mask_retain got v=%b pend=%h want 0 80", fx.out_valid, fx.pending);
        end
        fx.mask = 8'hFF;
        tick();
        checks++;
        if (fx.out_valid !== 1'b1 || fx.out_idx !== 3'd7 || fx.pending !== 8'h00) begin
            failures++;
            $display("FAIL mask_open got v=%b idx=%0d pend=%h want 1 7 00",
                     fx.out_valid, fx.out_idx, fx.pending);
        end
        tick();
    endtask

    task automatic test_overflow_clear();
        fx.out_ready = 1'b0;
        fx.req_in    = 8'h08;
        tick();
        fx.req_in = 8'h00;
        tick();
        // Index 3 is now held; next two pulses on bit 3 cannot be popped.
        fx.req_in = 8'h08;
        tick();
        checks++;
        if (fx.overflow !== 1'b0 || fx.pending !== 8'h08 || fx.out_idx !== 3'd3) begin
            failures++;
            $display("FAIL ovf_first got ovf=%b pend=%h idx=%0d want 0 08 3",
                     fx.overflow, fx.pending, fx.out_idx);
        end
        tick();
        fx.req_in = 8'h00;
        checks++;
        if (fx.overflow !== 1'b1 || fx.pending !== 8'h08) begin
            failures++;
            $display("FAIL ovf_pulse got ovf=%b pend=%h want 1 08", fx.overflow, fx.pending);
        end
        tick();
        checks++;
        if (fx.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_end got ovf=%b want 0", fx.overflow);
        end
        fx.clr_all = 1'b1;
        fx.req_in  = 8'h18;
        tick();
        fx.clr_all = 1'b0;
        fx.req_in  = 8'h00;
        checks++;
        if (fx.pending !== 8'h00 || fx.out_valid !== 1'b0 || fx.overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_all got pend=%h v=%b ovf=%b want 00 0 0",
                     fx.pending, fx.out_valid, fx.overflow);
        end
        tick();
        checks++;
        if (fx.pending !== 8'h00 || fx.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_drop got pend=%h v=%b want 00 0", fx.pending, fx.out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        rr.out_ready = 1'b0;
        rr.req_in    = 8'h01;
        tick();
        rr.req_in = 8'h00;
        tick();
        rr.req_in = 8'h0F;
        tick();
        rr.req_in = 8'h00;
        checks++;
        if (rr.out_valid !== 1'b1 || rr.out_idx !== 3'd0 || rr.pending !== 8'h0F) begin
            failures++;
            $display("FAIL rst_setup got v=%b idx=%0d pend=%h want 1 0 0f",
                     rr.out_valid, rr.out_idx, rr.pending);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rr.out_valid !== 1'b0 || rr.out_idx !== 3'd0 || rr.pending !== 8'h00 ||
            rr.overflow !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got v=%b idx=%0d pend=%h ovf=%b want 0 0 00 0",
                     rr.out_valid, rr.out_idx, rr.pending, rr.overflow);
        end
        #1;
        rst_n        = 1'b1;
        rr.out_ready = 1'b1;
        rr.req_in    = 8'h81;
        tick();
        rr.req_in = 8'h00;
        tick();
        checks++;
        if (rr.out_valid !== 1'b1 || rr.out_idx !== 3'd0) begin
            failures++;
            $display("FAIL rst_rr_restart got v=%b idx=%0d want 1 0", rr.out_valid, rr.out_idx);
        end
        tick();
        checks++;
        if (rr.out_valid !== 1'b1 || rr.out_idx !== 3'd7 || rr.pending !== 8'h00) begin
            failures++;
            $display("FAIL rst_rr_next got v=%b idx=%0d pend=%h want 1 7 00",
                     rr.out_valid, rr.out_idx, rr.pending);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        fx.req_in    = '0;
        fx.mask      = 8'hFF;
        fx.clr_all   = 1'b0;
        fx.out_ready = 1'b1;
        rr.req_in    = '0;
        rr.mask      = 8'hFF;
        rr.clr_all   = 1'b0;
        rr.out_ready = 1'b1;
        #3;
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_fixed_priority();
        test_backpressure();
        test_round_robin();
        test_masking();
        test_overflow_clear();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pend_priority_encoder.md
Name: pend_priority_encoder

Overview:
Parametrised, registered successor to the 4-bit combinational priority encoder. It latches single-cycle event requests from N channels into a sticky pending register. It then issues one channel index per cycle over a valid/ready handshake, using either fixed MSB-first priority or round-robin arbitration. It sits between interrupt/event sources and a single consumer that services one channel at a time.

Parameters:
N, 8, number of request channels (N >= 2)
IDX_W, 3, index width, equal to $clog2(N); must be consistent with N
RR_MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_in  input  N  event pulses; any bit high at a clock edge sets the matching pending bit
mask  input  N  1 = channel eligible for selection; masked pending bits are retained, not dropped
clr_all  input  1  synchronous clear of all pending bits and the output stage
out_idx  output  IDX_W  issued channel index
out_valid  output  1  out_idx holds an issued channel
out_ready  input  1  consumer accepts out_idx when out_valid && out_ready
pending  output  N  current pending register
overflow  output  1  one-cycle pulse: an event hit a channel already pending (event merged)

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - pending=0, out_valid=0, out_idx=0, overflow=0.
  - Round-robin pointer last=N-1, so the first search starts at channel 0.
- Candidate vector: cand = pending & mask.
- Load enable: load_en = !out_valid || out_ready. Sustained throughput is one index per cycle.
- On each edge with load_en:
  - If cand != 0: out_valid<=1, out_idx<=sel, and pending[sel] is cleared at the same edge (pop on load). In RR mode, last<=sel.
  - If cand == 0: out_valid<=0.
- Without load_en:
  - out_idx and out_valid hold stable.
  - Changes to pending or mask never alter an index that is already issued.
- Fixed mode: sel = highest-index set bit of cand. This matches the MSB-first priority of the 4-bit encoder.
- RR mode: sel = first set bit of cand searching upward from last+1, wrapping N-1 -> 0. The last-served channel has lowest priority.
- Pending update per bit i, in priority order:
  - clr_all -> 0 (concurrent req_in is dropped).
  - Otherwise req_in[i] -> 1 (a new event on the bit popped this same edge stays pending).
  - Otherwise, cleared if popped.
  - Otherwise, hold.
- Overflow: registered pulse high for one cycle after an edge where req_in[i]=1 and pending[i]=1 and bit i is not popped at that edge, for any i. Suppressed when clr_all is high.
- clr_all: at the edge, out_valid<=0 and pending<=0. The RR pointer is unchanged. clr_all overrides any load at the same edge.
- Latency:
  - req_in high in the cycle before edge E1 -> pending set after E1.
  - out_valid/out_idx presented after E2, if the output stage is free.
  - Latency is 2 edges minimum.
- Boundaries:
  - RR wrap from N-1 to 0.
  - All-masked pending gives out_valid=0 with pending retained.
  - N not a power of two: indices >= N are never produced.
  - Reset mid-transfer discards the held index with no accept.

Test Plan:
1. Fixed mode, N=8, out_ready=1. Pulse req_in=8'b0010_0101 for one cycle -> out_idx 5,2,0 on three consecutive cycles, first valid 2 edges after the pulse, then out_valid=0 and pending=0.
2. Backpressure. Pending 0x20, out_ready=0 -> out_idx=5 held; a req_in bit7 pulse arrives while held -> out_idx stays 5, pending=0x80. Raise out_ready -> next cycle out_idx=7.
3. RR mode. Hold req_in=8'hFF continuously, out_ready=1 -> out_idx sequence 0,1,2,...,7,0,1; overflow pulses while re-requests hit still-pending bits.
4. Masking. Pending 0x81, mask=0x7F -> issues 0 only, then out_valid=0 with pending=0x80. Set mask=0xFF -> out_idx=7.
5. Overflow/clr_all. Pulse req_in bit3 twice with out_ready=0 and out_valid held -> one overflow pulse. Assert clr_all -> pending=0, out_valid=0 next cycle, and a simultaneous req_in is dropped.
6. Reset mid-operation. With out_valid=1 and pending=0x0F, drop rst_n between edges -> outputs zero immediately; after release, RR restarts search at channel 0.
